// File: rtl/pos_pixel_scan.sv
// -----------------------------------------------------------------------------
// pos_pixel_scan
//
// Reads the n-body core's x/y position RAMs, body 0 up to num_bodies-1, and
// turns each IEEE-754 double pair into integer screen coordinates. The results
// leave as an ordered valid/ready pixel stream for the framebuffer writer.
// The scan is meant to run between simulation passes, while the core holds
// its done flag.
//
// Pipeline:
//   stage 0 : rd_en/rd_addr are issued to the RAMs (1-cycle read latency)
//   stage 1 : rd_x/rd_y return and are converted combinationally
//   stage 2 : the converted beat is written into a 4-entry output FIFO
// A read is only issued when FIFO occupancy plus in-flight reads is at most 3,
// so every beat already has a FIFO slot reserved when it lands.
//
// Optional feature (macro PIX_CLIP_EN):
//   When PIX_CLIP_EN is defined, offscreen beats are dropped at stage 2 and
//   give their credit back at that point.
//   When it is undefined, every body produces a beat and out_onscreen flags
//   whether it is visible.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, num_bodies scan request; num_bodies is sampled on an accepted start
//   busy, done        scan in progress / one-cycle completion pulse
//   rd_en, rd_addr    read request to the position RAMs
//   rd_x, rd_y        RAM read data, valid the cycle after rd_en
//   out_valid/ready   pixel stream handshake
//   out_idx, out_px, out_py, out_onscreen   pixel beat fields
// -----------------------------------------------------------------------------
module pos_pixel_scan #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int DATA_WIDTH      = 64,
  parameter int SCALE_SHIFT     = 0,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int PIX_W           = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BODY_ADDR_WIDTH-1:0] num_bodies,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [BODY_ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]      rd_x,
  input  logic [DATA_WIDTH-1:0]      rd_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BODY_ADDR_WIDTH-1:0] out_idx,
  output logic [PIX_W-1:0]           out_px,
  output logic [PIX_W-1:0]           out_py,
  output logic                       out_onscreen
);

  localparam int AW = BODY_ADDR_WIDTH;
  localparam int CW = PIX_W + 2;

  typedef logic signed [CW-1:0] coord_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0]    idx;
    logic [PIX_W-1:0] px;
    logic [PIX_W-1:0] py;
    logic             on;
  } beat_t;

  localparam coord_t          HALF_W   = coord_t'(SCREEN_W / 2);
  localparam coord_t          HALF_H   = coord_t'(SCREEN_H / 2);
  localparam coord_t          SCR_W    = coord_t'(SCREEN_W);
  localparam coord_t          SCR_H    = coord_t'(SCREEN_H);
  // Saturation magnitude 2^PIX_W-1 lands outside any screen once centred.
  localparam coord_t          SAT_MAG  = {2'b00, {PIX_W{1'b1}}};
  localparam logic [AW-1:0]   ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  // Double -> truncated signed integer after scaling by 2^SCALE_SHIFT.
  function automatic coord_t to_int(input logic [DATA_WIDTH-1:0] d);
    logic [10:0] e;
    logic [52:0] mant;
    logic [52:0] mag;
    int          k;
    coord_t      r;
    e    = d[62:52];
    mant = {1'b1, d[51:0]};
    k    = int'({21'd0, e}) - 32'sd1023 + SCALE_SHIFT;
    mag  = '0;
    if (e == 11'd0 || k < 32'sd0) begin
      r = '0;
    end else if (e == 11'h7FF || k >= PIX_W) begin
      r = d[63] ? -SAT_MAG : SAT_MAG;
    end else begin
      mag = mant >> (32'sd52 - k);
      r   = d[63] ? -coord_t'(mag) : coord_t'(mag);
    end
    return r;
  endfunction

  state_t        state;
  logic [AW-1:0] nb;
  logic          rd_pend;
  logic [AW-1:0] rd_idx;
  beat_t         fifo_mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    fifo_cnt;

  coord_t     ix, iy, px_c, py_c;
  logic       on_c;
  beat_t      beat_c;
  logic       push, pop;
  logic [2:0] cnt_next;
  logic       credit_ok;

  assign out_valid    = (fifo_cnt != 3'd0);
  assign out_idx      = fifo_mem[rd_ptr].idx;
  assign out_px       = fifo_mem[rd_ptr].px;
  assign out_py       = fifo_mem[rd_ptr].py;
  assign out_onscreen = fifo_mem[rd_ptr].on;

  // Stage 1 conversion, screen mapping, FIFO bookkeeping and read credit.
  always_comb begin
    ix   = to_int(rd_x);
    iy   = to_int(rd_y);
    px_c = ix + HALF_W;
    py_c = HALF_H - iy;                    // screen y grows downward
    on_c = !px_c[CW-1] && (px_c < SCR_W) && !py_c[CW-1] && (py_c < SCR_H);
    beat_c.idx = rd_idx;
    beat_c.px  = on_c ? px_c[PIX_W-1:0] : {PIX_W{1'b0}};
    beat_c.py  = on_c ? py_c[PIX_W-1:0] : {PIX_W{1'b0}};
    beat_c.on  = on_c;
`ifdef PIX_CLIP_EN
    push = rd_pend && on_c;
`else
    push = rd_pend;
`endif
    pop       = out_valid && out_ready;
    cnt_next  = fifo_cnt + {2'b00, push} - {2'b00, pop};
    // Occupancy after this edge plus the read now in flight must leave room.
    credit_ok = (cnt_next + {2'b00, rd_en}) <= 3'd3;
  end

  // Scan control FSM: read issue, stage-1 tracking, busy/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      nb      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_pend <= 1'b0;
      rd_idx  <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= rd_en;
      if (rd_en) begin
        rd_idx <= rd_addr;
      end
      case (state)
        IDLE: begin
          rd_en <= 1'b0;
          if (start) begin
            nb   <= num_bodies;
            busy <= 1'b1;
            if (num_bodies == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              rd_en   <= 1'b1;
              rd_addr <= '0;
              state   <= (num_bodies == ADDR_ONE) ? DRAIN : ISSUE;
            end
          end
        end
        ISSUE: begin
          if (credit_ok) begin
            rd_en   <= 1'b1;
            rd_addr <= rd_addr + ADDR_ONE;
            if ((rd_addr + ADDR_ONE) == (nb - ADDR_ONE)) begin
              state <= DRAIN;
            end
          end else begin
            rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          rd_en <= 1'b0;
          // Finish on the edge that empties the pipe so done follows the last handshake.
          if (cnt_next == 3'd0 && !rd_en) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          rd_en <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rd_en <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Four-entry output FIFO (stage 2 write, stream-side read).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= beat_c;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      fifo_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_pos_pixel_scan.sv
// -----------------------------------------------------------------------------
// tb_pos_pixel_scan
//
// Directed bench for pos_pixel_scan. A behavioural 1-cycle-latency RAM feeds
// both instances. dut uses default parameters. dut2 uses SCALE_SHIFT=2 and is
// only inspected in the scaling step. Expected beats are hand-computed.
// -----------------------------------------------------------------------------
module tb_pos_pixel_scan;

  localparam int AW = 9;
  localparam int PW = 12;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] num_bodies;
  logic          out_ready;
  logic [63:0]   rd_x, rd_y;

  logic          busy, done, rd_en, out_valid, out_onscreen;
  logic [AW-1:0] rd_addr, out_idx;
  logic [PW-1:0] out_px, out_py;

  logic          busy2, done2, rd_en2, out_valid2, out_onscreen2;
  logic [AW-1:0] rd_addr2, out_idx2;
  logic [PW-1:0] out_px2, out_py2;

  logic [63:0] xmem [0:15];
  logic [63:0] ymem [0:15];

  int e_idx [0:15];
  int e_px  [0:15];
  int e_py  [0:15];
  int e_on  [0:15];
  int n_exp;

  int n_checks, n_errors;
  int got, rd_cnt, rd_pre_hs, rd_first, first_v, done_cyc, last_hs, s2_px;

  pos_pixel_scan dut (
    .clk(clk), .rst(rst), .start(start), .num_bodies(num_bodies),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_x(rd_x), .rd_y(rd_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_px(out_px), .out_py(out_py),
    .out_onscreen(out_onscreen)
  );

  pos_pixel_scan #(.SCALE_SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .num_bodies(num_bodies),
    .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_x(rd_x), .rd_y(rd_y), .out_valid(out_valid2), .out_ready(out_ready),
    .out_idx(out_idx2), .out_px(out_px2), .out_py(out_py2),
    .out_onscreen(out_onscreen2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Position RAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_x <= xmem[rd_addr[3:0]];
      rd_y <= ymem[rd_addr[3:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setm(input int i, input logic [63:0] x, input logic [63:0] y);
    xmem[i] = x;
    ymem[i] = y;
  endtask

  task automatic add_exp(input int idx, input int px, input int py, input int on);
`ifdef PIX_CLIP_EN
    if (on == 0) return;
`endif
    e_idx[n_exp] = idx;
    e_px[n_exp]  = px;
    e_py[n_exp]  = py;
    e_on[n_exp]  = on;
    n_exp++;
  endtask

  // Pulse start and watch the stream until done, a reset abort, or the budget.
  task automatic scan(input int n, input int ready_at, input int restart_at,
                      input int rst_after, input int budget);
    logic        stalled, aborted;
    logic [31:0] h_idx, h_px, h_py;
    got = 0; rd_cnt = 0; rd_pre_hs = 0; rd_first = -1; first_v = -1;
    done_cyc = -1; last_hs = -1; s2_px = -1;
    stalled = 1'b0; aborted = 1'b0;
    h_idx = '0; h_px = '0; h_py = '0;
    @(negedge clk);
    start = 1'b1;
    num_bodies = n[AW-1:0];
    out_ready = (ready_at <= 0);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      num_bodies = (c == restart_at) ? 9'd5 : n[AW-1:0];
      out_ready = (c >= ready_at);
      #1;
      if (rd_en) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = c;
        if (last_hs < 0) rd_pre_hs++;
      end
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && stalled) begin
        chk("stall_idx", out_idx, h_idx);
        chk("stall_px", out_px, h_px);
        chk("stall_py", out_py, h_py);
      end
      stalled = out_valid && !out_ready;
      h_idx = out_idx; h_px = out_px; h_py = out_py;
      if (out_valid && out_ready) begin
        if (got < n_exp) begin
          chk("beat_idx", out_idx, e_idx[got]);
          chk("beat_px", out_px, e_px[got]);
          chk("beat_py", out_py, e_py[got]);
          chk("beat_on", out_onscreen, e_on[got]);
        end else begin
          chk("extra_beat", got, n_exp);
        end
        if (out_valid2 && s2_px < 0) s2_px = out_px2;
        got++;
        last_hs = c;
        if (got == rst_after) begin
          #2 rst = 1'b0;
          #1;
          chk("mid_rst_busy", busy, 0);
          chk("mid_rst_done", done, 0);
          chk("mid_rst_rd_en", rd_en, 0);
          chk("mid_rst_rd_addr", rd_addr, 0);
          chk("mid_rst_valid", out_valid, 0);
          chk("mid_rst_idx", out_idx, 0);
          chk("mid_rst_px", out_px, 0);
          chk("mid_rst_py", out_py, 0);
          chk("mid_rst_on", out_onscreen, 0);
          @(negedge clk);
          rst = 1'b1;
          aborted = 1'b1;
        end
      end
      if (aborted) break;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    if (!aborted) chk("done_seen", (done_cyc > 0), 1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    start = 1'b0; num_bodies = '0; out_ready = 1'b0; rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      xmem[i] = 64'd0;
      ymem[i] = 64'd0;
    end

    // Reset state
    #1 rst = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_onscreen", out_onscreen, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_px", out_px, 0);
    chk("rst_py", out_py, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic conversion
    setm(0, $realtobits(0.0), $realtobits(0.0));
    setm(1, $realtobits(1.5), $realtobits(-2.0));
    setm(2, $realtobits(-100.0), $realtobits(50.0));
    n_exp = 0;
    add_exp(0, 320, 240, 1);
    add_exp(1, 321, 242, 1);
    add_exp(2, 220, 190, 1);
    scan(3, 0, -1, -1, 40);
    chk("basic_beats", got, 3);
    chk("basic_rd_first", rd_first, 1);
    chk("basic_rd_cnt", rd_cnt, 3);
    chk("basic_first_valid", first_v, 3);
    chk("basic_done_after_hs", done_cyc, last_hs + 1);
    @(negedge clk); #1;
    chk("basic_busy_clear", busy, 0);
    chk("basic_done_pulse", done, 0);

    // Offscreen body
    setm(0, $realtobits(400.0), $realtobits(0.0));
    n_exp = 0;
    add_exp(0, 0, 0, 0);
    scan(1, 0, -1, -1, 40);
    chk("off_beats", got, n_exp);

    // Special values: +inf, NaN, tiny/-0.0
    setm(0, 64'h7FF0_0000_0000_0000, 64'd0);
    setm(1, 64'h7FF8_0000_0000_0000, 64'd0);
    setm(2, $realtobits(1e-300), 64'h8000_0000_0000_0000);
    n_exp = 0;
    add_exp(0, 0, 0, 0);
    add_exp(1, 0, 0, 0);
    add_exp(2, 320, 240, 1);
    scan(3, 0, -1, -1, 40);
    chk("special_beats", got, n_exp);

    // Scaling: x=1.75 gives 1 at shift 0 and 7 at shift 2
    setm(0, $realtobits(1.75), $realtobits(0.0));
    n_exp = 0;
    add_exp(0, 321, 240, 1);
    scan(1, 0, -1, -1, 40);
    chk("scale_px", s2_px, 327);

    // Backpressure: ready low for 10 cycles
    for (int i = 0; i < 8; i++) setm(i, $realtobits(real'(i)), $realtobits(0.0));
    n_exp = 0;
    for (int i = 0; i < 8; i++) add_exp(i, 320 + i, 240, 1);
    scan(8, 10, -1, -1, 80);
    chk("bp_beats", got, 8);
    chk("bp_rd_limit", (rd_pre_hs <= 4) && (rd_pre_hs > 0), 1);
    chk("bp_rd_cnt", rd_cnt, 8);

    // Zero bodies
    n_exp = 0;
    scan(0, 0, -1, -1, 10);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_rd_cnt", rd_cnt, 0);
    chk("zero_no_valid", first_v, -1);

    // Start while busy is ignored
    setm(0, $realtobits(0.0), $realtobits(0.0));
    setm(1, $realtobits(1.5), $realtobits(-2.0));
    setm(2, $realtobits(-100.0), $realtobits(50.0));
    n_exp = 0;
    add_exp(0, 320, 240, 1);
    add_exp(1, 321, 242, 1);
    add_exp(2, 220, 190, 1);
    scan(3, 0, 2, -1, 40);
    chk("restart_beats", got, 3);
    chk("restart_rd_cnt", rd_cnt, 3);

    // Reset after 3 beats, then rescan from index 0
    for (int i = 0; i < 8; i++) setm(i, $realtobits(real'(i)), $realtobits(0.0));
    n_exp = 0;
    for (int i = 0; i < 8; i++) add_exp(i, 320 + i, 240, 1);
    scan(8, 0, -1, 3, 40);
    chk("rst_abort_beats", got, 3);
    repeat (2) @(negedge clk);
    scan(2, 0, -1, -1, 40);
    chk("rescan_beats", got, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
